// File: rtl/intf_share_arb_pkg.sv
// Shared types for the interface-sharing round-robin arbiter: FSM state
// encoding and the owner-index width helper.
package intf_share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Owner index width; a single requester still needs one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intf_share_arb_rr_pick.sv
// Combinational round-robin pick: the lowest requester at or above ptr wins,
// otherwise the lowest requester overall (wrap-around).
module rr_pick
  import intf_share_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             any,
  output logic [IW-1:0]    winner
);

  logic [N_REQ-1:0] masked;
  logic             found_m;
  logic             found_u;
  logic [IW-1:0]    win_m;
  logic [IW-1:0]    win_u;

  always_comb begin
    masked  = '0;
    found_m = 1'b0;
    found_u = 1'b0;
    win_m   = '0;
    win_u   = '0;
    any     = |req;
    for (int i = 0; i < N_REQ; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (masked[i] && !found_m) begin
        found_m = 1'b1;
        win_m   = IW'(i);
      end
      if (req[i] && !found_u) begin
        found_u = 1'b1;
        win_u   = IW'(i);
      end
    end
    winner = found_m ? win_m : win_u;
  end

endmodule

// File: rtl/intf_share_arb.sv
// Round-robin owner arbiter for a shared interface instance: hold-until-release
// grant, one-cycle turnaround gap, fair rotation. Optional hold watchdog is
// compiled in with `define INTF_SHARE_ARB_TIMEOUT_EN.
module intf_share_arb
  import intf_share_arb_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int MAX_HOLD = 16,
  parameter  int CNT_W    = 8,
  localparam int IW       = id_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] rel,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_id,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt,
  output logic             timeout
);

  // Reject configurations the grant and watchdog logic cannot represent.
  if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 1 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_param
    $error("intf_share_arb: illegal N_REQ/MAX_HOLD/CNT_W combination");
  end

  arb_state_e       state_q;
  arb_state_e       state_n;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_n;
  logic [N_REQ-1:0] gnt_n;
  logic [IW-1:0]    gnt_id_n;
  logic [CNT_W-1:0] hold_n;
  logic             timeout_n;
  logic             pick_any;
  logic [IW-1:0]    pick_win;
  logic             owner_rel;
  logic             watchdog;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_win)
  );

  assign busy = (state_q == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_n;
      ptr_q    <= ptr_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      hold_cnt <= hold_n;
      timeout  <= timeout_n;
    end
  end

  // Next-state logic; the owner gives up the bus by pulsing rel or dropping req,
  // and a release always wins over a concurrent request from the same owner.
  always_comb begin
    state_n   = state_q;
    ptr_n     = ptr_q;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    hold_n    = hold_cnt;
    timeout_n = 1'b0;
    owner_rel = rel[gnt_id] | ~req[gnt_id];
`ifdef INTF_SHARE_ARB_TIMEOUT_EN
    watchdog  = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
    watchdog  = 1'b0;
`endif

    case (state_q)
      IDLE, GAP: begin
        hold_n = '0;
        gnt_n  = '0;
        if (pick_any) begin
          state_n  = GRANT;
          gnt_n    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_win;
          gnt_id_n = pick_win;
          ptr_n    = (pick_win == IW'(N_REQ - 1)) ? '0 : pick_win + 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (owner_rel || watchdog) begin
          state_n   = GAP;
          gnt_n     = '0;
          hold_n    = '0;
          timeout_n = watchdog & ~owner_rel;
        end else if (hold_cnt != {CNT_W{1'b1}}) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        hold_n  = '0;
      end
    endcase
  end

endmodule

// File: doc/intf_share_arb.md
Name: intf_share_arb

Overview:
- Round-robin arbiter that shares one interface instance (for example `intf #(.PARAM(n))`) among N_REQ requester modules.
- Sits beside the shared interface inside a generate scope; its grant vector drives the interface's ownership mux.
- Provides a hold-until-release grant, a one-cycle bus turnaround gap, and fair rotation.

Parameters:
- N_REQ, 4, number of requesters; legal range is 2 to 16.
- MAX_HOLD, 16, maximum grant length in cycles; only used with the optional timeout.
- CNT_W, 8, width of the hold-cycle counter output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester request level.
- rel  input  N_REQ  per-requester release pulse.
- gnt  output  N_REQ  one-hot grant; all zeros when nobody owns the interface.
- gnt_id  output  $clog2(N_REQ)  index of the current owner.
- busy  output  1  high while in GRANT.
- hold_cnt  output  CNT_W  cycles the current owner has held the grant; saturating.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (asynchronous, on rst_n low):
  - state=IDLE, gnt=0, gnt_id=0, busy=0, hold_cnt=0, timeout=0, ptr=0.
  - Reset asserted mid-grant drops gnt immediately. No release is signalled to the owner.
- States and transitions:
  - IDLE: if req!=0, winner = first set bit of req searching from ptr upward with wrap. Next cycle: GRANT, gnt=onehot(winner), gnt_id=winner, ptr=(winner+1) mod N_REQ. If req=0, stay in IDLE.
  - GRANT: release = rel[gnt_id] | ~req[gnt_id].
    - On release: go to GAP and clear gnt.
    - Otherwise: hold, and hold_cnt increments, saturating at 2^CNT_W-1.
  - GAP: exactly one cycle with gnt=0 (turnaround).
    - Arbitration runs in this cycle as in IDLE: go to GRANT if any req, else to IDLE.
    - hold_cnt clears to 0 on entry to GAP.
- Latency:
  - From IDLE: req high at edge t gives gnt high after edge t+1.
  - Back-to-back: release sampled at edge t, gnt=0 during cycle t+1, the next grant is visible after edge t+2.
- Boundary cases:
  - rel on a non-owner is ignored.
  - rel and req from the same owner in the same cycle: release wins.
  - ptr wraps from N_REQ-1 to 0.
  - A lone requester re-wins after each GAP.
  - gnt is always one-hot or zero; gnt_id holds its last value while gnt=0.
- busy == (state==GRANT).
- timeout is 0 unless the optional feature is compiled in.

Optional Feature:
- Macro: INTF_SHARE_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt == MAX_HOLD-1 and there is no release that cycle, force a transition to GAP exactly as for a release.
  - timeout pulses high for the GAP cycle.
  - ptr still advances, so the timed-out requester loses priority.
- Undefined:
  - No watchdog; the grant is held indefinitely.
  - timeout is tied to 0 and MAX_HOLD is unused.

Decomposition:
- Package intf_share_arb_pkg holds:
  - state typedef enum logic [1:0] {IDLE, GRANT, GAP}.
  - Function for the gnt_id width.
- Sub-module rr_pick (combinational):
  - Inputs: req, ptr.
  - Outputs: any, winner.
  - Method: masked/unmasked priority encode.
- The arbiter instantiates rr_pick once and contains the FSM, ptr, and counter.

Test Plan:
- Reset and idle: rst_n=0 for 3 cycles, then req=0 for 5 cycles -> gnt=0, busy=0, gnt_id=0, hold_cnt=0 throughout.
- Single requester: req=4'b0100 at cycle 10 -> gnt=4'b0100 and gnt_id=2 from cycle 11. rel[2] pulsed at cycle 15 -> gnt=0 at 16, regrant at 17 with hold_cnt restarting at 0.
- Round-robin fairness: req=4'b1111 held, each owner releases after 2 cycles -> grant order 0,1,2,3,0 with exactly one zero-gnt gap cycle between grants.
- Non-owner and simultaneous events:
  - With owner 1, pulse rel=4'b0100 -> no change.
  - rel[1] together with req[1]=1 -> GAP.
  - Owner dropping req[1] without rel -> GAP.
- Reset mid-grant: rst_n falls asynchronously during GRANT of id 3 -> gnt=0 before the next edge. After release, req=4'b1001 -> id 0 granted (ptr back to 0).
- Timeout (macro on, MAX_HOLD=4): req[0] held with no rel -> gnt for 4 cycles, timeout=1 in the GAP cycle. With req=4'b0011 the next grant goes to id 1. With the macro off, the same stimulus holds the grant for at least 50 cycles and timeout stays 0.
